// File: rtl/fir_pkg.sv
// fir_pkg: FSM state type and width helpers shared by the time-multiplexed FIR.
// Used by fir_mac and fir_tdm.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_IDX_W = 1;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

  // Accumulator width large enough that summing taps products never overflows.
  function automatic int acc_w(input int bits, input int taps);
    return 2 * bits + $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: one signed multiply feeding a clearable accumulator.
// acc_sum is the combinational running total including the current product.
module fir_mac
  import fir_pkg::*;
#(
  parameter int BITS_PER_ELEM = 8,
  parameter int ACC_BITS      = acc_w(8, 7)
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            en,
  input  logic signed [BITS_PER_ELEM-1:0] coef,
  input  logic signed [BITS_PER_ELEM-1:0] sample,
  output logic signed [ACC_BITS-1:0]      acc_sum
);

  localparam int PROD_W = 2 * BITS_PER_ELEM;

  logic signed [PROD_W-1:0]   prod_p0;
  logic signed [ACC_BITS-1:0] prod_ext_p0;
  logic signed [ACC_BITS-1:0] acc_p1;

  // Stage p0: product of the selected coefficient and delay tap
  assign prod_p0     = coef * sample;
  assign prod_ext_p0 = $signed({{(ACC_BITS - PROD_W){prod_p0[PROD_W-1]}}, prod_p0});
  assign acc_sum     = acc_p1 + prod_ext_p0;

  // Stage p1: accumulator register; clear wins over accumulate
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= acc_sum;
    end
  end

endmodule

// File: rtl/fir_tdm.sv
// fir_tdm: multi-channel FIR sharing one sequential MAC over a common delay line.
// Define FIR_SAT_EN to saturate channel outputs instead of wrapping them.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int BITS_PER_ELEM  = 8,
  parameter int NUM_ELEM       = 7,
  parameter int NUM_CHAN       = 4,
  parameter int SUM_TRUNCATION = 8,
  parameter int ACC_BITS       = acc_w(BITS_PER_ELEM, NUM_ELEM),
  parameter int OUT_SHIFT      = ACC_BITS - SUM_TRUNCATION,
  parameter logic [NUM_CHAN*NUM_ELEM*BITS_PER_ELEM-1:0] FILTER_VAL = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [BITS_PER_ELEM-1:0]    i_sample,
  input  logic                               i_sample_valid,
  output logic                               o_ready,
  input  logic                               i_coef_we,
  input  logic [idx_w(NUM_CHAN)-1:0]         i_coef_chan,
  input  logic [idx_w(NUM_ELEM)-1:0]         i_coef_idx,
  input  logic signed [BITS_PER_ELEM-1:0]    i_coef,
  output logic [NUM_CHAN*SUM_TRUNCATION-1:0] o_wavelet,
  output logic                               o_valid
);

  localparam int CHAN_W = idx_w(NUM_CHAN);
  localparam int TAP_W  = idx_w(NUM_ELEM);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NUM_ELEM - 1);

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX =
    ACC_BITS'((64'sd1 <<< (SUM_TRUNCATION - 1)) - 64'sd1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;
`endif

  state_t state, state_nxt;
  logic [CHAN_W-1:0] chan;
  logic [TAP_W-1:0]  tap;

  logic signed [BITS_PER_ELEM-1:0]  delay [NUM_ELEM];
  logic signed [BITS_PER_ELEM-1:0]  coef  [NUM_CHAN][NUM_ELEM];
  logic signed [SUM_TRUNCATION-1:0] stage [NUM_CHAN];

  logic accept, coef_wr, chan_ok, tap_ok;
  logic mac_clr, mac_en;
  logic signed [BITS_PER_ELEM-1:0]  mac_coef, mac_sample;
  logic signed [ACC_BITS-1:0]       acc_sum;
  logic signed [SUM_TRUNCATION-1:0] chan_res;

  // Scale the accumulator to the output width, either clamping or wrapping.
  function automatic logic signed [SUM_TRUNCATION-1:0] reduce(
    input logic signed [ACC_BITS-1:0] acc
  );
`ifdef FIR_SAT_EN
    logic signed [ACC_BITS-1:0] shifted;
    shifted = acc >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      return SAT_MAX[SUM_TRUNCATION-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[SUM_TRUNCATION-1:0];
    end
    return shifted[SUM_TRUNCATION-1:0];
`else
    return acc[OUT_SHIFT +: SUM_TRUNCATION];
`endif
  endfunction

  assign o_ready = (state == IDLE);
  assign accept  = i_sample_valid && (state == IDLE);
  assign chan_ok = (int'(i_coef_chan) < NUM_CHAN);
  assign tap_ok  = (int'(i_coef_idx) < NUM_ELEM);
  assign coef_wr = i_coef_we && (state == IDLE) && chan_ok && tap_ok;

  assign mac_coef   = coef[chan][tap];
  assign mac_sample = delay[tap];
  assign chan_res   = reduce(acc_sum);

  fir_mac #(
    .BITS_PER_ELEM (BITS_PER_ELEM),
    .ACC_BITS      (ACC_BITS)
  ) u_mac (
    .clk     (clk),
    .clr     (mac_clr),
    .en      (mac_en),
    .coef    (mac_coef),
    .sample  (mac_sample),
    .acc_sum (acc_sum)
  );

  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CALC;
          mac_clr   = 1'b1;
        end
      end
      CALC: begin
        mac_en = 1'b1;
        if (tap == LAST_TAP) begin
          mac_clr = 1'b1;
          if (chan == LAST_CHAN) begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last channel bypasses staging so all results publish on the final MAC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chan      <= '0;
      tap       <= '0;
      o_valid   <= 1'b0;
      o_wavelet <= '0;
      for (int t = 0; t < NUM_ELEM; t++) begin
        delay[t] <= '0;
      end
      for (int c = 0; c < NUM_CHAN; c++) begin
        for (int t = 0; t < NUM_ELEM; t++) begin
          coef[c][t] <= FILTER_VAL[(c*NUM_ELEM+t)*BITS_PER_ELEM +: BITS_PER_ELEM];
        end
      end
    end else begin
      state   <= state_nxt;
      o_valid <= 1'b0;
      if (coef_wr) begin
        coef[i_coef_chan][i_coef_idx] <= i_coef;
      end
      if (accept) begin
        delay[0] <= i_sample;
        for (int t = 1; t < NUM_ELEM; t++) begin
          delay[t] <= delay[t-1];
        end
        chan <= '0;
        tap  <= '0;
      end
      if (state == CALC) begin
        if (tap == LAST_TAP) begin
          tap  <= '0;
          chan <= chan + 1'b1;
          if (chan == LAST_CHAN) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
              o_wavelet[c*SUM_TRUNCATION +: SUM_TRUNCATION] <=
                (c == NUM_CHAN - 1) ? chan_res : stage[c];
            end
            o_valid <= 1'b1;
          end
        end else begin
          tap <= tap + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == CALC) && (tap == LAST_TAP)) begin
      stage[chan] <= chan_res;
    end
  end

endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: directed vectors for fir_tdm with a default-shift and a zero-shift instance.
// Expected outputs come from a direct sum-of-products model plus hand-computed tables.
module tb_fir_tdm;

  localparam int BITS      = 8;
  localparam int TAPS      = 7;
  localparam int CHANS     = 4;
  localparam int TRUNC     = 8;
  localparam int ACC_BITS  = 2 * BITS + $clog2(TAPS) + 1;
  localparam int SHIFT_DEF = ACC_BITS - TRUNC;
  localparam int CALC_LEN  = CHANS * TAPS;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] i_sample;
  logic              i_sample_valid;
  logic              i_coef_we;
  logic [1:0]        i_coef_chan;
  logic [2:0]        i_coef_idx;
  logic signed [7:0] i_coef;
  logic              o_ready, o_valid, o_ready_s0, o_valid_s0;
  logic [31:0]       o_wavelet, o_wavelet_s0;

  always #5 clk = ~clk;

  fir_tdm dut (
    .clk            (clk),
    .rst            (rst),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_ready        (o_ready),
    .i_coef_we      (i_coef_we),
    .i_coef_chan    (i_coef_chan),
    .i_coef_idx     (i_coef_idx),
    .i_coef         (i_coef),
    .o_wavelet      (o_wavelet),
    .o_valid        (o_valid)
  );

  fir_tdm #(.OUT_SHIFT(0)) dut_s0 (
    .clk            (clk),
    .rst            (rst),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_ready        (o_ready_s0),
    .i_coef_we      (i_coef_we),
    .i_coef_chan    (i_coef_chan),
    .i_coef_idx     (i_coef_idx),
    .i_coef         (i_coef),
    .o_wavelet      (o_wavelet_s0),
    .o_valid        (o_valid_s0)
  );

  int n_checks = 0;
  int n_err    = 0;
  int m_coef  [CHANS][TAPS];
  int m_delay [TAPS];

  typedef struct {
    int sample;
    int exp_wrap;
    int exp_sat;
  } imp_vec_t;
  imp_vec_t imp_tbl [7];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_out(input int ch, input int shift);
    longint acc;
    longint sh;
    logic signed [7:0] low;
    acc = 0;
    for (int t = 0; t < TAPS; t++) begin
      acc += longint'(m_coef[ch][t]) * longint'(m_delay[t]);
    end
    sh = acc >>> shift;
`ifdef FIR_SAT_EN
    if (sh > 127) sh = 127;
    else if (sh < -128) sh = -128;
`endif
    low = sh[7:0];
    return low;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANS; c++)
      for (int t = 0; t < TAPS; t++) m_coef[c][t] = 0;
    for (int t = 0; t < TAPS; t++) m_delay[t] = 0;
  endtask

  task automatic model_shift(input int s);
    for (int t = TAPS - 1; t > 0; t--) m_delay[t] = m_delay[t-1];
    m_delay[0] = s;
  endtask

  task automatic check_all(input string tag);
    logic signed [7:0] a, b;
    for (int ch = 0; ch < CHANS; ch++) begin
      a = o_wavelet[ch*8 +: 8];
      b = o_wavelet_s0[ch*8 +: 8];
      check($sformatf("%s ch%0d shift%0d", tag, ch, SHIFT_DEF), a, model_out(ch, SHIFT_DEF));
      check($sformatf("%s ch%0d shift0", tag, ch), b, model_out(ch, 0));
    end
  endtask

  task automatic write_coef(input int c, input int i, input int v);
    i_coef_we   = 1'b1;
    i_coef_chan = 2'(c);
    i_coef_idx  = 3'(i);
    i_coef      = 8'(v);
    tick();
    i_coef_we = 1'b0;
    if (c < CHANS && i < TAPS) m_coef[c][i] = v;
  endtask

  task automatic wait_ready(input string tag);
    int waitc;
    waitc = 0;
    while (!o_ready && waitc < 200) begin
      tick();
      waitc++;
    end
    check({tag, " ready before accept"}, o_ready, 1);
  endtask

  // One accept with an optional same-cycle write and an optional write attempt mid-CALC.
  task automatic run_calc(input int s, input bit wr, input int wc, input int wi, input int wv,
                          input bit bad_we, input string tag);
    int vpos, vcount, vcount_s0, rlow;
    wait_ready(tag);
    i_sample       = 8'(s);
    i_sample_valid = 1'b1;
    if (wr) begin
      i_coef_we   = 1'b1;
      i_coef_chan = 2'(wc);
      i_coef_idx  = 3'(wi);
      i_coef      = 8'(wv);
    end
    tick();
    i_sample_valid = 1'b0;
    i_coef_we      = 1'b0;
    if (wr && wc < CHANS && wi < TAPS) m_coef[wc][wi] = wv;
    model_shift(s);
    rlow      = o_ready ? 0 : 1;
    vpos      = -1;
    vcount    = 0;
    vcount_s0 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bad_we && k == 5) begin
        i_coef_we   = 1'b1;
        i_coef_chan = 2'd2;
        i_coef_idx  = 3'd0;
        i_coef      = 8'sd100;
      end
      if (k == 6) i_coef_we = 1'b0;
      tick();
      if (o_valid) begin
        vcount++;
        if (vpos < 0) vpos = k;
      end
      if (o_valid_s0) vcount_s0++;
      if (!o_ready) rlow++;
    end
    check({tag, " valid edge"}, vpos, CALC_LEN);
    check({tag, " valid pulses"}, vcount, 1);
    check({tag, " valid pulses shift0"}, vcount_s0, 1);
    check({tag, " ready low cycles"}, rlow, CALC_LEN + 1);
    check_all(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts, first_acc, last_acc, vcnt;
    logic signed [7:0] ch_val;
    longint exp_v;

    imp_tbl[0] = '{64,   64,  64};
    imp_tbl[1] = '{0,  -128, 127};
    imp_tbl[2] = '{0,   -64, 127};
    imp_tbl[3] = '{0,     0, 127};
    imp_tbl[4] = '{0,    64, 127};
    imp_tbl[5] = '{0,  -128, 127};
    imp_tbl[6] = '{0,   -64, 127};

    // Reset with a sample and a write offered; both must be ignored.
    rst = 1'b1; i_sample = 8'sd99; i_sample_valid = 1'b1;
    i_coef_we = 1'b1; i_coef_chan = 2'd0; i_coef_idx = 3'd0; i_coef = 8'sd50;
    model_reset();
    tick(); tick(); tick();
    check("ready during rst", o_ready, 1);
    check("valid during rst", o_valid, 0);
    rst = 1'b0; i_sample_valid = 1'b0; i_coef_we = 1'b0;
    tick();
    check("reset ready", o_ready, 1);
    check_all("reset");

    run_calc(100, 1'b0, 0, 0, 0, 1'b0, "default coef");

    run_calc(-128, 1'b1, 0, 0, 127, 1'b0, "load c0t0");
    ch_val = o_wavelet[7:0];
    check("load ch0 hand", ch_val, longint'(-16256) >>> SHIFT_DEF);
    ch_val = o_wavelet_s0[7:0];
    check("load ch0 shift0 hand", ch_val, -128);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < TAPS; t++) write_coef(1, t, t + 1);
    for (int i = 0; i < 7; i++) begin
      run_calc(imp_tbl[i].sample, 1'b0, 0, 0, 0, 1'b0, $sformatf("impulse %0d", i));
      ch_val = o_wavelet_s0[15:8];
`ifdef FIR_SAT_EN
      exp_v = imp_tbl[i].exp_sat;
`else
      exp_v = imp_tbl[i].exp_wrap;
`endif
      check($sformatf("impulse ch1 table %0d", i), ch_val, exp_v);
    end

    // Out-of-range tap in the accept cycle plus a write attempt during CALC.
    run_calc(10, 1'b1, 0, 7, 55, 1'b1, "writes outside idle");

    wait_ready("mid reset");
    i_sample = 8'sd77; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    vcnt = 0;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (o_valid || o_valid_s0) vcnt++;
    end
    check("mid reset valid pulses", vcnt, 0);
    check("mid reset ready", o_ready, 1);
    check("mid reset wavelet", o_wavelet, 0);
    check_all("mid reset");
    write_coef(2, 0, 3);
    write_coef(2, 1, 2);
    run_calc(10, 1'b0, 0, 0, 0, 1'b0, "post reset");
    ch_val = o_wavelet_s0[23:16];
    check("post reset ch2 hand", ch_val, 30);

    // Sustained back-pressure: valid held high for 100 cycles.
    i_sample = 8'sd5;
    i_sample_valid = 1'b1;
    accepts = 0; first_acc = -1; last_acc = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (o_ready) begin
        accepts++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        model_shift(5);
      end
      tick();
    end
    i_sample_valid = 1'b0;
    check("backpressure accepts", accepts, 4);
    check("backpressure spacing", last_acc - first_acc, 3 * (CALC_LEN + 2));
    wait_ready("backpressure drain");
    check_all("backpressure");
    repeat (5) tick();
    check_all("output hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
